// File: rtl/vdp_pkg.sv
// Shared VDP definitions: VRAM address width default, VRAM access FSM state
// encoding, setup-command decode of the second control byte, and the queued
// VRAM operation payload.
package vdp_pkg;

   localparam int unsigned VRAM_AW_DEF = 14;
   localparam int unsigned DATA_W      = 8;

   // VRAM access sequencer states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR_WAIT = 2'd2
   } vram_state_t;

   // Top two bits of the second control byte
   typedef enum logic [1:0] {
      CMD_RD_SETUP = 2'b00,
      CMD_WR_SETUP = 2'b01,
      CMD_REG_A    = 2'b10,
      CMD_REG_B    = 2'b11
   } setup_cmd_t;

   // A VRAM operation waiting for, or being placed on, the VRAM bus
   typedef struct packed {
      logic              we;
      logic [DATA_W-1:0] data;
   } vram_op_t;

   // Wait state entered when an operation is put on the bus
   function automatic vram_state_t wait_state(input logic we);
      return we ? ST_WR_WAIT : ST_RD_WAIT;
   endfunction

endpackage

// File: rtl/vdp_cpu_ifce_if.sv
// VRAM request/acknowledge bus between the CPU interface (master) and the
// VRAM arbiter/memory (slave).
//   vram_req/vram_we/vram_addr/vram_wdata : master -> slave, held until ack
//   vram_ack/vram_rdata                   : slave -> master, rdata valid with ack
interface vdp_cpu_ifce_if #(
   parameter int unsigned AW = vdp_pkg::VRAM_AW_DEF
) ();

   logic          vram_req;
   logic          vram_we;
   logic [AW-1:0] vram_addr;
   logic [7:0]    vram_wdata;
   logic          vram_ack;
   logic [7:0]    vram_rdata;

   modport master (
      output vram_req, vram_we, vram_addr, vram_wdata,
      input  vram_ack, vram_rdata
   );

   modport slave (
      input  vram_req, vram_we, vram_addr, vram_wdata,
      output vram_ack, vram_rdata
   );

endinterface

// File: rtl/vdp_sync_edge.sv
// Two-flop synchronizer for an asynchronous strobe plus registered edge detect.
//   clk, reset : block clock, async active-high reset (strobe idles high)
//   async_in   : raw asynchronous input
//   level      : synchronized level
//   rise, fall : one-clk pulses coincident with the level change
module vdp_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         level  <= 1'b1;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         level  <= sync_q;
         rise   <= sync_q & ~level;
         fall   <= ~sync_q & level;
      end
   end

endmodule

// File: rtl/vdp_cpu_ifce.sv
// CPU port of the VDP: synchronizes the asynchronous CPU strobes, decodes
// control-port (mode 1) register writes/reads and VRAM address setup, and
// turns data-port (mode 0) accesses into VRAM bus transactions with a
// read-ahead buffer and a one-deep pending slot.
//   clk, reset                 : clock, async active-high reset
//   cpu_csw_n/csr_n/mode/din   : asynchronous CPU bus inputs
//   cpu_dout                   : byte returned to the CPU, held between reads
//   reg_wr_tick/reg_din        : control-port write strobe and data
//   reg_rd_tick/status_rd_tick : control-port read completion strobes
//   status_in                  : status byte presented on control-port reads
//   overrun                    : sticky, a data-port access was lost
//   vram                       : VRAM request/ack bus (master side)
module vdp_cpu_ifce
   import vdp_pkg::*;
#(
   parameter int unsigned VRAM_AW = VRAM_AW_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_csw_n,
   input  logic                  cpu_csr_n,
   input  logic                  cpu_mode,
   input  logic [7:0]            cpu_din,
   output logic [7:0]            cpu_dout,
   output logic                  reg_wr_tick,
   output logic                  reg_rd_tick,
   output logic [7:0]            reg_din,
   input  logic [7:0]            status_in,
   output logic                  status_rd_tick,
   output logic                  overrun,
   vdp_cpu_ifce_if.master        vram
);

   // synchronized strobes
   logic csw_lvl, csw_rise, csw_fall;
   logic csr_lvl, csr_rise, csr_fall;
   logic mode_lvl, mode_rise, mode_fall;

   vdp_sync_edge u_sync_csw (
      .clk(clk), .reset(reset), .async_in(cpu_csw_n),
      .level(csw_lvl), .rise(csw_rise), .fall(csw_fall)
   );

   vdp_sync_edge u_sync_csr (
      .clk(clk), .reset(reset), .async_in(cpu_csr_n),
      .level(csr_lvl), .rise(csr_rise), .fall(csr_fall)
   );

   vdp_sync_edge u_sync_mode (
      .clk(clk), .reset(reset), .async_in(cpu_mode),
      .level(mode_lvl), .rise(mode_rise), .fall(mode_fall)
   );

   logic unused_edges;
   assign unused_edges = ^{csw_fall, csr_lvl, mode_rise, mode_fall};

   // registered state
   vram_state_t        state_q, state_d;
   logic [7:0]         latch_q;
   logic               toggle_q;
   logic [7:0]         addr_lo_q;
   logic [VRAM_AW-1:0] ptr_q, ptr_d;
   logic [7:0]         buf_q;
   logic               pend_v_q;
   vram_op_t           pend_op_q;
   logic [VRAM_AW-1:0] pend_addr_q;
   logic               rd_fall_dly_q, rd_rise_dly_q;
   logic               vram_req_q, vram_we_q;
   logic [VRAM_AW-1:0] vram_addr_q;
   logic [7:0]         vram_wdata_q;

   // decoded events for this clk
   logic               rd_fall_ev, rd_rise_ev;
   logic               wr_reg, wr_vram, rd_reg, rd_vram;
   setup_cmd_t         cmd;
   logic               load_addr, prefetch;
   logic [VRAM_AW-1:0] base_ptr;
   logic               new_v;
   vram_op_t           new_op;

   // FSM controls
   logic               issue, pend_set, pend_clr, drop;
   vram_op_t           iss_op;
   logic [VRAM_AW-1:0] iss_addr;

   // CPU event decode; a read coinciding with a write is replayed next clk
   always_comb begin : decode
      rd_fall_ev = (csr_fall & ~csw_rise) | rd_fall_dly_q;
      rd_rise_ev = (csr_rise & ~csw_rise) | rd_rise_dly_q;
      wr_reg     = csw_rise & mode_lvl;
      wr_vram    = csw_rise & ~mode_lvl;
      rd_reg     = rd_rise_ev & mode_lvl;
      rd_vram    = rd_rise_ev & ~mode_lvl;
      cmd        = setup_cmd_t'(latch_q[7:6]);
      load_addr  = wr_reg & toggle_q &
                   ((cmd == CMD_RD_SETUP) || (cmd == CMD_WR_SETUP));
      prefetch   = load_addr & (cmd == CMD_RD_SETUP);
      base_ptr   = load_addr ? VRAM_AW'({latch_q[5:0], addr_lo_q}) : ptr_q;
      new_v      = wr_vram | rd_vram | prefetch;
      new_op.we   = wr_vram;
      new_op.data = latch_q;
   end

   // VRAM sequencer next state; pending slot drains the clk after ack
   always_comb begin : vram_fsm
      state_d  = state_q;
      issue    = 1'b0;
      iss_op   = pend_op_q;
      iss_addr = pend_addr_q;
      pend_set = 1'b0;
      pend_clr = 1'b0;
      drop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pend_v_q) begin
               issue    = 1'b1;
               pend_clr = 1'b1;
               pend_set = new_v;
            end else if (new_v) begin
               issue    = 1'b1;
               iss_op   = new_op;
               iss_addr = base_ptr;
            end
         end
         ST_RD_WAIT, ST_WR_WAIT: begin
            if (vram.vram_ack) begin
               state_d = ST_IDLE;
            end
            if (new_v) begin
               if (pend_v_q) begin
                  drop = 1'b1;
               end else begin
                  pend_set = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (issue) begin
         state_d = wait_state(iss_op.we);
      end
      // address advances when an access is accepted, not when it completes
      ptr_d = (new_v & ~drop) ? base_ptr + VRAM_AW'(1) : base_ptr;
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // datapath, pending slot and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         latch_q        <= 8'h00;
         toggle_q       <= 1'b0;
         addr_lo_q      <= 8'h00;
         ptr_q          <= '0;
         buf_q          <= 8'h00;
         pend_v_q       <= 1'b0;
         pend_op_q      <= '0;
         pend_addr_q    <= '0;
         rd_fall_dly_q  <= 1'b0;
         rd_rise_dly_q  <= 1'b0;
         cpu_dout       <= 8'h00;
         reg_wr_tick    <= 1'b0;
         reg_rd_tick    <= 1'b0;
         status_rd_tick <= 1'b0;
         reg_din        <= 8'h00;
         overrun        <= 1'b0;
         vram_req_q     <= 1'b0;
         vram_we_q      <= 1'b0;
         vram_addr_q    <= '0;
         vram_wdata_q   <= 8'h00;
      end else begin
         reg_wr_tick    <= wr_reg;
         reg_rd_tick    <= rd_reg;
         status_rd_tick <= rd_reg;
         rd_fall_dly_q  <= csr_fall & csw_rise;
         rd_rise_dly_q  <= csr_rise & csw_rise;

         if (!csw_lvl) begin
            latch_q <= cpu_din;
         end
         if (wr_reg) begin
            reg_din  <= latch_q;
            toggle_q <= ~toggle_q;
            if (!toggle_q) begin
               addr_lo_q <= latch_q;
            end
         end else if (rd_reg) begin
            toggle_q <= 1'b0;
         end

         if (rd_fall_ev) begin
            cpu_dout <= mode_lvl ? status_in : buf_q;
         end
         if ((state_q == ST_RD_WAIT) && vram.vram_ack) begin
            buf_q <= vram.vram_rdata;
         end

         ptr_q <= ptr_d;
         if (pend_set) begin
            pend_v_q    <= 1'b1;
            pend_op_q   <= new_op;
            pend_addr_q <= base_ptr;
         end else if (pend_clr) begin
            pend_v_q <= 1'b0;
         end
         if (drop) begin
            overrun <= 1'b1;
         end

         // bus fields change only on issue or once the sequencer is idle
         vram_req_q <= (state_d != ST_IDLE);
         if (issue) begin
            vram_we_q    <= iss_op.we;
            vram_addr_q  <= iss_addr;
            vram_wdata_q <= iss_op.data;
         end else if (state_d == ST_IDLE) begin
            vram_we_q   <= 1'b0;
            vram_addr_q <= ptr_d;
         end
      end
   end

   assign vram.vram_req   = vram_req_q;
   assign vram.vram_we    = vram_we_q;
   assign vram.vram_addr  = vram_addr_q;
   assign vram.vram_wdata = vram_wdata_q;

endmodule

// File: tb/tb_vdp_cpu_ifce.sv
// Directed bench for vdp_cpu_ifce: CPU strobe driver, VRAM responder with a
// programmable ack delay and a transaction log, strobe pulse counters.
module tb_vdp_cpu_ifce;

   logic       clk = 1'b0;
   logic       reset;
   logic       cpu_csw_n, cpu_csr_n, cpu_mode;
   logic [7:0] cpu_din, cpu_dout, reg_din, status_in;
   logic       reg_wr_tick, reg_rd_tick, status_rd_tick, overrun;

   int checks = 0;
   int errors = 0;

   vdp_cpu_ifce_if #(.AW(14)) vram ();

   vdp_cpu_ifce #(.VRAM_AW(14)) dut (
      .clk(clk), .reset(reset),
      .cpu_csw_n(cpu_csw_n), .cpu_csr_n(cpu_csr_n), .cpu_mode(cpu_mode),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout),
      .reg_wr_tick(reg_wr_tick), .reg_rd_tick(reg_rd_tick), .reg_din(reg_din),
      .status_in(status_in), .status_rd_tick(status_rd_tick),
      .overrun(overrun), .vram(vram)
   );

   always #5 clk = ~clk;

   // VRAM contents seen by reads
   function automatic logic [7:0] vram_content(input logic [13:0] a);
      if (a == 14'h3FFF) return 8'h11;
      if (a == 14'h0000) return 8'h22;
      return a[7:0] ^ 8'h5A;
   endfunction

   // VRAM responder and transaction log
   int          ack_delay = 2;
   int          cnt;
   int          log_n = 0;
   logic        log_we   [0:31];
   logic [13:0] log_addr [0:31];
   logic [7:0]  log_data [0:31];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         vram.vram_ack   <= 1'b0;
         vram.vram_rdata <= 8'h00;
         cnt             <= 0;
      end else begin
         vram.vram_ack <= 1'b0;
         if (vram.vram_req && !vram.vram_ack) begin
            if (cnt >= ack_delay) begin
               vram.vram_ack <= 1'b1;
               cnt           <= 0;
               if (!vram.vram_we) vram.vram_rdata <= vram_content(vram.vram_addr);
               if (log_n < 32) begin
                  log_we[log_n]   <= vram.vram_we;
                  log_addr[log_n] <= vram.vram_addr;
                  log_data[log_n] <= vram.vram_wdata;
               end
               log_n <= log_n + 1;
            end else begin
               cnt <= cnt + 1;
            end
         end else if (!vram.vram_req) begin
            cnt <= 0;
         end
      end
   end

   // strobe pulse counters
   int         wr_ticks = 0, rd_ticks = 0, st_ticks = 0, req_rises = 0;
   logic [7:0] last_din = 8'h00;
   logic       req_prev = 1'b0;

   always @(posedge clk) begin
      if (reg_wr_tick) begin
         wr_ticks <= wr_ticks + 1;
         last_din <= reg_din;
      end
      if (reg_rd_tick) rd_ticks <= rd_ticks + 1;
      if (status_rd_tick) st_ticks <= st_ticks + 1;
      if (vram.vram_req && !req_prev) req_rises <= req_rises + 1;
      req_prev <= vram.vram_req;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cpu_write(input logic m, input logic [7:0] d, input int hold);
      cpu_mode = m;
      tick(1);
      cpu_din   = d;
      cpu_csw_n = 1'b0;
      tick(hold);
      cpu_csw_n = 1'b1;
      tick(hold);
   endtask

   task automatic cpu_read(input logic m, input int hold);
      cpu_mode = m;
      tick(1);
      cpu_csr_n = 1'b0;
      tick(hold);
      cpu_csr_n = 1'b1;
      tick(hold);
   endtask

   initial begin
      int snap;
      int waited;
      reset     = 1'b1;
      cpu_csw_n = 1'b1;
      cpu_csr_n = 1'b1;
      cpu_mode  = 1'b0;
      cpu_din   = 8'h00;
      status_in = 8'h00;
      tick(3);

      // reset state
      check("rst_req",     vram.vram_req, 0);
      check("rst_we",      vram.vram_we, 0);
      check("rst_addr",    vram.vram_addr, 0);
      check("rst_wdata",   vram.vram_wdata, 0);
      check("rst_dout",    cpu_dout, 0);
      check("rst_overrun", overrun, 0);
      check("rst_ticks",   {reg_wr_tick, reg_rd_tick, status_rd_tick}, 0);
      reset = 1'b0;
      tick(5);
      check("idle_req", vram.vram_req, 0);

      // control writes 0x05, 0x81: one tick each, no VRAM traffic
      cpu_write(1'b1, 8'h05, 6);
      check("wr1_ticks", wr_ticks, 1);
      check("wr1_din",   last_din, 8'h05);
      cpu_write(1'b1, 8'h81, 6);
      check("wr2_ticks", wr_ticks, 2);
      check("wr2_din",   last_din, 8'h81);
      check("reg_no_vram", log_n, 0);

      // write setup 0x1234, data writes 0xAA, 0xBB
      cpu_write(1'b1, 8'h34, 6);
      cpu_write(1'b1, 8'h52, 6);
      check("setup_no_vram", log_n, 0);
      cpu_write(1'b0, 8'hAA, 6);
      tick(10);
      cpu_write(1'b0, 8'hBB, 6);
      tick(10);
      check("wr_count", log_n, 2);
      check("wr0_we",   log_we[0], 1);
      check("wr0_addr", log_addr[0], 14'h1234);
      check("wr0_data", log_data[0], 8'hAA);
      check("wr1_we",   log_we[1], 1);
      check("wr1_addr", log_addr[1], 14'h1235);
      check("wr1_data", log_data[1], 8'hBB);

      // read setup at 0x3FFF, prefetch then wrap to 0x0000
      cpu_write(1'b1, 8'hFF, 6);
      cpu_write(1'b1, 8'h3F, 6);
      tick(10);
      check("pf_we",   log_we[2], 0);
      check("pf_addr", log_addr[2], 14'h3FFF);
      cpu_read(1'b0, 6);
      tick(10);
      check("rd1_dout", cpu_dout, 8'h11);
      check("rd1_addr", log_addr[3], 14'h0000);
      check("rd1_we",   log_we[3], 0);
      cpu_read(1'b0, 6);
      tick(10);
      check("rd2_dout", cpu_dout, 8'h22);
      check("rd2_addr", log_addr[4], 14'h0001);

      // status read clears the byte toggle
      cpu_write(1'b1, 8'h12, 6);
      status_in = 8'h80;
      cpu_read(1'b1, 6);
      check("st_dout",  cpu_dout, 8'h80);
      check("st_ticks", st_ticks, 1);
      check("rr_ticks", rd_ticks, 1);
      cpu_write(1'b1, 8'h34, 6);
      cpu_write(1'b1, 8'h40, 6);
      cpu_write(1'b0, 8'h77, 6);
      tick(10);
      check("tgl_count", log_n, 6);
      check("tgl_we",    log_we[5], 1);
      check("tgl_addr",  log_addr[5], 14'h0034);
      check("tgl_data",  log_data[5], 8'h77);
      check("pre_overrun", overrun, 0);

      // slow ack: issue, pend, drop
      cpu_write(1'b1, 8'h00, 6);
      cpu_write(1'b1, 8'h41, 6);
      ack_delay = 20;
      cpu_write(1'b0, 8'hA1, 4);
      cpu_write(1'b0, 8'hB2, 4);
      cpu_write(1'b0, 8'hC3, 4);
      tick(80);
      check("ovr_flag",  overrun, 1);
      check("ovr_count", log_n, 8);
      check("ovr0_addr", log_addr[6], 14'h0100);
      check("ovr0_data", log_data[6], 8'hA1);
      check("ovr1_addr", log_addr[7], 14'h0101);
      check("ovr1_data", log_data[7], 8'hB2);

      // reset during RD_WAIT
      cpu_write(1'b1, 8'h00, 6);
      cpu_write(1'b1, 8'h00, 6);
      waited = 0;
      while (!vram.vram_req && waited < 40) begin
         tick(1);
         waited++;
      end
      check("rdw_req_seen", vram.vram_req, 1);
      tick(3);
      reset = 1'b1;
      #1;
      check("rdw_req_drop", vram.vram_req, 0);
      check("rdw_overrun",  overrun, 0);
      check("rdw_addr",     vram.vram_addr, 0);
      check("rdw_dout",     cpu_dout, 0);
      tick(3);
      reset = 1'b0;
      snap = req_rises;
      tick(40);
      check("rdw_no_req", req_rises, snap);
      snap = log_n;
      cpu_read(1'b0, 6);
      tick(40);
      check("rdw_buf_zero", cpu_dout, 8'h00);
      check("rdw_new_rd",   log_addr[snap], 14'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vdp_cpu_ifce.md
VDP_CPU_IFCE -- requirements
Module: vdp_cpu_ifce

Interface
REQ-001 Parameter VRAM_AW, default 14, VRAM address width.
REQ-002 clk  in  1  system clock; sole clock of the block.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cpu_csw_n, cpu_csr_n, cpu_mode  in  1 each  CPU write strobe, read strobe and port select (0 = VRAM data, 1 = control/status); all asynchronous to clk.
REQ-005 cpu_din  in  8  CPU write data, stable while cpu_csw_n low; cpu_dout  out  8  CPU read data.
REQ-006 reg_wr_tick, reg_rd_tick  out  1  one-clk strobes for mode-1 write/read; reg_din  out  8  data valid during reg_wr_tick.
REQ-007 status_in  in  8  status byte; status_rd_tick  out  1  one-clk strobe on completion of a status read.
REQ-008 vram_req, vram_we  out  1; vram_addr  out  VRAM_AW; vram_wdata  out  8; vram_ack  in  1; vram_rdata  in  8  (valid when vram_ack high).
REQ-009 overrun  out  1  sticky: a CPU VRAM access was lost.

Function
REQ-010 The block SHALL pass cpu_csw_n, cpu_csr_n and cpu_mode through a 2-FF synchronizer and act only on synchronized edges.
REQ-011 The block SHALL capture cpu_din into a data latch on every clk while synchronized csw_n is low.
REQ-012 On synchronized csw_n rising edge with mode=1, the block SHALL assert reg_wr_tick with reg_din = latched data for exactly one clk.
REQ-013 The block SHALL keep a byte toggle: cleared by reset and by reg_rd_tick, inverted on each mode-1 write; first byte stored in addr_lo.
REQ-014 On a second mode-1 write with data[7:6]=01, vram_addr SHALL load {data[5:0], addr_lo} (VRAM write setup); with 00 it SHALL load the same and issue a VRAM read prefetch; with 10 or 11 the address SHALL be unchanged.
REQ-015 On synchronized csr_n falling edge, cpu_dout SHALL load status_in (mode=1) or the read-ahead buffer (mode=0) and hold until the next read.
REQ-016 On synchronized csr_n rising edge with mode=1, reg_rd_tick and status_rd_tick SHALL assert for one clk.
REQ-017 On csr_n rising edge with mode=0, the block SHALL issue a VRAM read at vram_addr to refill the read-ahead buffer, then increment the address.
REQ-018 On csw_n rising edge with mode=0, the block SHALL issue a VRAM write of latched data at vram_addr, then increment the address.
REQ-019 Address increment SHALL wrap 2^VRAM_AW-1 -> 0.
REQ-020 VRAM FSM states IDLE, RD_WAIT, WR_WAIT: IDLE->RD_WAIT/WR_WAIT on issue with vram_req=1; vram_req, vram_we, vram_addr and vram_wdata stable until vram_ack; ack -> IDLE, buffer <= vram_rdata on RD_WAIT ack.
REQ-021 An access issued while not IDLE SHALL occupy a one-deep pending slot issued the clk after ack; an access arriving while the slot is full SHALL be dropped and set overrun.
REQ-022 Address increment SHALL occur at issue time, so pending accesses use consecutive addresses.
REQ-023 vram_ack in IDLE SHALL be ignored.
REQ-024 Simultaneous synchronized csr_n and csw_n edges SHALL process the write first, then the read, on the next clk.

Reset
REQ-025 On reset: all ticks, vram_req, vram_we and overrun = 0; vram_addr, vram_wdata, cpu_dout, read-ahead buffer, addr_lo, toggle and data latch = 0; FSM = IDLE; pending slot empty; synchronizers = 1 (strobes idle).
REQ-026 Reset asserted mid-transaction SHALL abandon it; no vram_req after reset release until a new CPU access occurs.

Structure
REQ-027 VRAM_AW default and the FSM state encoding SHALL live in shared package vdp_pkg.
REQ-028 Synchronizer plus edge detect SHALL be sub-module vdp_sync_edge (outputs level, rise, fall), instantiated per strobe.

Verification
REQ-029 Mode-1 writes 0x05, 0x81 -> one reg_wr_tick each, reg_din 0x05 then 0x81; toggle returns to 0.
REQ-030 Mode-1 writes 0x34, 0x52; mode-0 writes 0xAA, 0xBB -> VRAM writes 0xAA@0x1234, 0xBB@0x1235.
REQ-031 Mode-1 writes 0xFF, 0x3F (read setup) with VRAM[0x3FFF]=0x11, VRAM[0x0000]=0x22 -> prefetch reads 0x3FFF; mode-0 read returns 0x11; address wraps to 0x0000; buffer becomes 0x22.
REQ-032 vram_ack held off 20 clks; three mode-0 writes back-to-back -> first issued, second pending, third dropped, overrun=1.
REQ-033 Mode-1 write 0x12, mode-1 read (status_in=0x80) -> cpu_dout=0x80, status_rd_tick one clk, toggle cleared; next write 0x34 treated as first byte.
REQ-034 Reset asserted during RD_WAIT -> vram_req=0 immediately, FSM IDLE, all outputs per REQ-025.
